// File: rtl/stream_fifo_pkg.sv
// Shared constants and elaboration helpers for the stream FIFO slice.
package stream_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_AFULL_MARGIN = 2;
  localparam int DEF_AEMPTY_LEVEL = 2;

  // Occupancy ranges over 0..depth inclusive, hence depth+1 states.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Write/read handshake plus occupancy status bundled as one port group.
interface stream_fifo_if
  import stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  logic                          in_ready;
  logic                          in_enable;
  logic [WIDTH-1:0]              in_data;
  logic                          out_ready;
  logic                          out_enable;
  logic [WIDTH-1:0]              out_data;
  logic [count_width(DEPTH)-1:0] count;
  logic                          almost_full;
  logic                          almost_empty;

  // The FIFO itself sits on the slave side; producer/consumer drive the master side.
  modport slave (
    input  in_enable, in_data, out_ready,
    output in_ready, out_enable, out_data, count, almost_full, almost_empty
  );

  modport master (
    output in_enable, in_data, out_ready,
    input  in_ready, out_enable, out_data, count, almost_full, almost_empty
  );

endinterface

// File: rtl/stream_fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; only the pointers decide which words are live,
  // and non-blocking writes keep the array a clean register-file inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with occupancy count and threshold flags.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int AFULL_LEVEL  = DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_LEVEL = DEF_AEMPTY_LEVEL
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  stream_fifo_if.slave  s
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "stream_fifo: WIDTH must be at least 1");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $fatal(1, "stream_fifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL_LEVEL < 0 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $fatal(1, "stream_fifo: AFULL_LEVEL must lie in 0..DEPTH");
  end
  if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH) begin : g_bad_aempty
    $fatal(1, "stream_fifo: AEMPTY_LEVEL must lie in 0..DEPTH");
  end

  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_COUNT  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_COUNT = CW'(AEMPTY_LEVEL);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          wr_en;
  logic          rd_en;

  // Status is decoded from the count register alone, so out_ready never
  // reaches in_ready combinationally.
  assign s.in_ready     = (count_q != FULL_COUNT);
  assign s.out_enable   = (count_q != '0);
  assign s.count        = count_q;
  assign s.almost_full  = (count_q >= AFULL_COUNT);
  assign s.almost_empty = (count_q <= AEMPTY_COUNT);

  assign wr_en = s.in_ready && s.in_enable;
  assign rd_en = s.out_enable && s.out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // Pointers wrap modulo DEPTH for free because DEPTH is a power of two.
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en)      count_q <= count_q + CW'(1);
      else if (rd_en && !wr_en) count_q <= count_q - CW'(1);
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en && !reset && !flush),
    .waddr (wr_ptr),
    .wdata (s.in_data),
    .raddr (rd_ptr),
    .rdata (s.out_data)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: directed table, corner sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_stream_fifo;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 14;
  localparam int AEMPTY = 2;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  stream_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stream_fifo #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .AFULL_LEVEL  (AFULL),
    .AEMPTY_LEVEL (AEMPTY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .s     (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int n_pops = 0;

  logic [WIDTH-1:0] model [$];

  typedef struct {
    logic             ie;
    logic [WIDTH-1:0] d;
    logic             ordy;
    logic             fl;
    logic             rs;
    int               ecount;
    logic             eod_valid;
    logic [WIDTH-1:0] eod;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = model.size();
    check("model_count",   32'(bus.count),       32'(sz));
    check("model_in_rdy",  32'(bus.in_ready),    32'(sz != DEPTH));
    check("model_out_en",  32'(bus.out_enable),  32'(sz != 0));
    check("model_afull",   32'(bus.almost_full), 32'(sz >= AFULL));
    check("model_aempty",  32'(bus.almost_empty),32'(sz <= AEMPTY));
    if (sz != 0) check("model_head", 32'(bus.out_data), 32'(model[0]));
  endtask

  // One clock: drive inputs, let the edge happen, update the model, then compare.
  task automatic cycle(input logic ie, input logic [WIDTH-1:0] d, input logic ordy,
                       input logic fl, input logic rs);
    bit w;
    bit r;
    bus.in_enable = ie;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    reset         = rs;
    @(posedge clk);
    if (rs || fl) begin
      model.delete();
    end else begin
      w = ie && (model.size() < DEPTH);
      r = ordy && (model.size() > 0);
      if (r) begin
        void'(model.pop_front());
        n_pops++;
      end
      if (w) model.push_back(d);
    end
    #1;
    check_model();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},  32'(bus.count),        32'd0);
    check({tag, "_in_rdy"}, 32'(bus.in_ready),     32'd1);
    check({tag, "_out_en"}, 32'(bus.out_enable),   32'd0);
    check({tag, "_aempty"}, 32'(bus.almost_empty), 32'd1);
    check({tag, "_afull"},  32'(bus.almost_full),  32'd0);
  endtask

  initial begin
    int pops0;
    int ec;
    bus.in_enable = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    reset         = 1'b1;

    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 1);
    check_reset_state("reset");

    // Directed table from an empty FIFO: expected state after each edge.
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h11};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2, 1'b1, 8'h11};
    tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 2, 1'b1, 8'h22};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h33};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h44};
    tbl[7]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h66};
    tbl[9]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 0, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h3C};
    tbl[11] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h5A};
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].ie, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].rs);
      ec = tbl[i].ecount;
      check("tbl_count",  32'(bus.count),      32'(ec));
      check("tbl_in_rdy", 32'(bus.in_ready),   32'(ec != DEPTH));
      check("tbl_out_en", 32'(bus.out_enable), 32'(ec != 0));
      if (tbl[i].eod_valid) check("tbl_data", 32'(bus.out_data), 32'(tbl[i].eod));
    end

    // Fill 0x00..0x0F with the consumer stalled.
    cycle(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 8'(i), 0, 0, 0);
      check("fill_afull",  32'(bus.almost_full),  32'((i + 1) >= AFULL));
      check("fill_aempty", 32'(bus.almost_empty), 32'((i + 1) <= AEMPTY));
    end
    check("fill_count",  32'(bus.count),    32'd16);
    check("fill_in_rdy", 32'(bus.in_ready), 32'd0);
    cycle(1, 8'hEE, 0, 0, 0);
    check("overflow_count", 32'(bus.count), 32'd16);

    // Drain in order.
    check("drain_head0", 32'(bus.out_data), 32'h00);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 8'h00, 1, 0, 0);
      if (i < DEPTH - 1) check("drain_head", 32'(bus.out_data), 32'(i + 1));
    end
    check("drain_count",  32'(bus.count),      32'd0);
    check("drain_out_en", 32'(bus.out_enable), 32'd0);

    // Full plus concurrent read: read only, then the write is accepted.
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'($urandom), 0, 0, 0);
    cycle(1, 8'hC3, 1, 0, 0);
    check("fullrd_count", 32'(bus.count), 32'd15);
    cycle(1, 8'hC4, 0, 0, 0);
    check("fullrd_next_count", 32'(bus.count), 32'd16);

    // Continuous streaming of 100 words through a one-deep occupancy.
    cycle(0, 8'h00, 0, 0, 1);
    pops0 = n_pops;
    for (int i = 0; i < 100; i++) begin
      cycle(1, 8'(i * 7 + 3), 1, 0, 0);
      check("stream_count", 32'(bus.count), 32'd1);
    end
    cycle(0, 8'h00, 1, 0, 0);
    check("stream_reads", 32'(n_pops - pops0), 32'd100);
    check("stream_empty", 32'(bus.out_enable), 32'd0);

    // Flush at count 5 discards the concurrent write.
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h80 + i), 0, 0, 0);
    check("pre_flush_count", 32'(bus.count), 32'd5);
    cycle(1, 8'h77, 0, 1, 0);
    check("flush_count", 32'(bus.count), 32'd0);
    cycle(1, 8'hA5, 0, 0, 0);
    check("flush_first", 32'(bus.out_data), 32'hA5);

    // Reset mid-burst at count 9 alongside flush.
    cycle(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 9; i++) cycle(1, 8'(8'h40 + i), 0, 0, 0);
    check("pre_reset_count", 32'(bus.count), 32'd9);
    cycle(1, 8'h99, 1, 1, 1);
    check_reset_state("midreset");
    cycle(1, 8'h3C, 0, 0, 0);
    check("midreset_first", 32'(bus.out_data), 32'h3C);

    // Randomized traffic with phases biased toward filling and draining.
    for (int i = 0; i < 3000; i++) begin
      logic ie;
      logic ordy;
      if (((i / 150) % 2) == 0) begin
        ie   = ($urandom_range(0, 9) < 8);
        ordy = ($urandom_range(0, 9) < 3);
      end else begin
        ie   = ($urandom_range(0, 9) < 3);
        ordy = ($urandom_range(0, 9) < 8);
      end
      cycle(ie, 8'($urandom), ordy,
            ($urandom_range(0, 99) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
